// File: rtl/bus_enable_sync_if.sv
// Source-to-destination bus bundle for bus_enable_sync: raw data plus qualifier in,
// captured data, strobe and transfer count out.
interface bus_enable_sync_if #(
   parameter int unsigned BUS_WIDTH = 8,
   parameter int unsigned CNT_WIDTH = 8
) ();
   logic [BUS_WIDTH-1:0] UNSYNC_BUS;
   logic                 BUS_ENABLE;
   logic [BUS_WIDTH-1:0] SYNC_BUS;
   logic                 ENABLE_PULSE;
   logic [CNT_WIDTH-1:0] EVENT_COUNT;

   modport master (
      output UNSYNC_BUS,
      output BUS_ENABLE,
      input  SYNC_BUS,
      input  ENABLE_PULSE,
      input  EVENT_COUNT
   );

   modport slave (
      input  UNSYNC_BUS,
      input  BUS_ENABLE,
      output SYNC_BUS,
      output ENABLE_PULSE,
      output EVENT_COUNT
   );
endinterface

// File: rtl/bus_enable_sync.sv
// Enable-qualified multi-bit CDC: only BUS_ENABLE crosses a NUM_STAGES flop chain; the bus is
// captured once on a synchronised enable edge. Define TOGGLE_MODE_EN for toggle-encoded enables.
module bus_enable_sync #(
   parameter int unsigned BUS_WIDTH  = 8,
   parameter int unsigned NUM_STAGES = 2,
   parameter int unsigned CNT_WIDTH  = 8
) (
   input  logic              CLK,
   input  logic              RST,
   bus_enable_sync_if.slave  bus
);

   generate
      if (NUM_STAGES < 2 || NUM_STAGES > 5) begin : g_bad_num_stages
         $error("bus_enable_sync: NUM_STAGES must be in 2..5");
      end
   endgenerate

   logic [NUM_STAGES-1:0] sync_chain;
   logic                  sync_en;
   logic                  prev_en;
   logic                  event_c;
   logic [BUS_WIDTH-1:0]  sync_bus_q;
   logic                  enable_pulse_q;
   logic [CNT_WIDTH-1:0]  event_count_q;

   // Enable synchroniser; bit 0 is the first stage
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_chain <= '0;
         prev_en    <= 1'b0;
      end else begin
         sync_chain <= {sync_chain[NUM_STAGES-2:0], bus.BUS_ENABLE};
         prev_en    <= sync_en;
      end
   end

   assign sync_en = sync_chain[NUM_STAGES-1];

`ifdef TOGGLE_MODE_EN
   assign event_c = sync_en ^ prev_en;
`else
   assign event_c = sync_en & ~prev_en;
`endif

   // One-shot capture; the bus is stable by the time the enable edge leaves the chain
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_bus_q     <= '0;
         enable_pulse_q <= 1'b0;
         event_count_q  <= '0;
      end else begin
         enable_pulse_q <= event_c;
         if (event_c) begin
            sync_bus_q    <= bus.UNSYNC_BUS;
            event_count_q <= event_count_q + CNT_WIDTH'(1);
         end
      end
   end

   assign bus.SYNC_BUS     = sync_bus_q;
   assign bus.ENABLE_PULSE = enable_pulse_q;
   assign bus.EVENT_COUNT  = event_count_q;

endmodule

// File: tb/tb_bus_enable_sync.sv
// Randomised bench for bus_enable_sync: three depth/counter variants driven in lockstep and
// compared every cycle against a delayed-sample reference model.
module tb_bus_enable_sync;

   localparam int NUM_DUT = 3;
   localparam int N_ST [NUM_DUT] = '{2, 4, 5};
   localparam int C_W  [NUM_DUT] = '{8, 2, 8};

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   bus_enable_sync_if #(.BUS_WIDTH(8), .CNT_WIDTH(8)) bif0 ();
   bus_enable_sync_if #(.BUS_WIDTH(8), .CNT_WIDTH(2)) bif1 ();
   bus_enable_sync_if #(.BUS_WIDTH(8), .CNT_WIDTH(8)) bif2 ();

   bus_enable_sync #(.BUS_WIDTH(8), .NUM_STAGES(2), .CNT_WIDTH(8)) dut0 (.CLK(CLK), .RST(RST), .bus(bif0));
   bus_enable_sync #(.BUS_WIDTH(8), .NUM_STAGES(4), .CNT_WIDTH(2)) dut1 (.CLK(CLK), .RST(RST), .bus(bif1));
   bus_enable_sync #(.BUS_WIDTH(8), .NUM_STAGES(5), .CNT_WIDTH(8)) dut2 (.CLK(CLK), .RST(RST), .bus(bif2));

   logic [7:0] o_bus   [NUM_DUT];
   logic       o_pulse [NUM_DUT];
   logic [7:0] o_cnt   [NUM_DUT];
   assign o_bus[0] = bif0.SYNC_BUS;  assign o_pulse[0] = bif0.ENABLE_PULSE;  assign o_cnt[0] = bif0.EVENT_COUNT;
   assign o_bus[1] = bif1.SYNC_BUS;  assign o_pulse[1] = bif1.ENABLE_PULSE;  assign o_cnt[1] = 8'(bif1.EVENT_COUNT);
   assign o_bus[2] = bif2.SYNC_BUS;  assign o_pulse[2] = bif2.ENABLE_PULSE;  assign o_cnt[2] = bif2.EVENT_COUNT;

   // Reference model: enable samples seen since reset, and the expected outputs
   bit         hist [$];
   logic [7:0] exp_bus   [NUM_DUT];
   logic       exp_pulse [NUM_DUT];
   int         exp_cnt   [NUM_DUT];
   bit         cur_en;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic bit en_at(input int i);
      return (i < 0) ? 1'b0 : hist[i];
   endfunction

   task automatic model_clear();
      hist.delete();
      for (int j = 0; j < NUM_DUT; j++) begin
         exp_bus[j]   = '0;
         exp_pulse[j] = 1'b0;
         exp_cnt[j]   = 0;
      end
   endtask

   task automatic check_all(input string tag);
      for (int j = 0; j < NUM_DUT; j++) begin
         chk($sformatf("%s.sync_bus[%0d]", tag, j),     32'(o_bus[j]),   32'(exp_bus[j]));
         chk($sformatf("%s.enable_pulse[%0d]", tag, j), 32'(o_pulse[j]), 32'(exp_pulse[j]));
         chk($sformatf("%s.event_count[%0d]", tag, j),  32'(o_cnt[j]),   32'(exp_cnt[j]));
      end
   endtask

   task automatic drive(input bit en, input logic [7:0] d);
      bif0.BUS_ENABLE = en;  bif0.UNSYNC_BUS = d;
      bif1.BUS_ENABLE = en;  bif1.UNSYNC_BUS = d;
      bif2.BUS_ENABLE = en;  bif2.UNSYNC_BUS = d;
   endtask

   // One CLK cycle: a transfer lands NUM_STAGES edges after the enable transition is sampled
   task automatic cycle(input bit en, input logic [7:0] d);
      int t;
      bit cur, prv, ev;
      drive(en, d);
      hist.push_back(en);
      t = hist.size() - 1;
      for (int j = 0; j < NUM_DUT; j++) begin
         cur = en_at(t - N_ST[j]);
         prv = en_at(t - N_ST[j] - 1);
`ifdef TOGGLE_MODE_EN
         ev = cur ^ prv;
`else
         ev = cur & ~prv;
`endif
         exp_pulse[j] = ev;
         if (ev) begin
            exp_bus[j] = d;
            exp_cnt[j] = (exp_cnt[j] + 1) % (1 << C_W[j]);
         end
      end
      @(posedge CLK);
      #1;
      check_all("run");
   endtask

   // One transfer: data held for 'hold' cycles around the enable change, then 'gap' noisy cycles
   task automatic xfer(input logic [7:0] d, input int hold, input int gap);
`ifdef TOGGLE_MODE_EN
      cur_en = !cur_en;
`else
      cur_en = 1'b1;
`endif
      repeat (hold) cycle(cur_en, d);
`ifndef TOGGLE_MODE_EN
      cur_en = 1'b0;
`endif
      repeat (gap) cycle(cur_en, 8'($urandom));
   endtask

   initial begin
      int cnt0;
      RST    = 1'b1;
      cur_en = 1'b0;
      drive(1'b0, 8'h00);
      model_clear();
      repeat (3) @(posedge CLK);
      #1;
      check_all("reset");
      RST = 1'b0;

      // Single transfer, enable held well beyond the sync depth
      xfer(8'hA5, 6, 8);
      chk("single.sync_bus", 32'(o_bus[0]), 32'h0000_00A5);
      chk("single.count",    32'(o_cnt[0]), 32'd1);

      // Bus noise with a quiet enable
      repeat (50) cycle(cur_en, 8'($urandom));
      chk("noise.sync_bus", 32'(o_bus[0]), 32'h0000_00A5);

      // Short back-to-back sequence
      cnt0 = int'(o_cnt[0]);
      xfer(8'h11, 4, 4);
      xfer(8'h22, 4, 4);
      xfer(8'h33, 4, 4);
      chk("seq.sync_bus", 32'(o_bus[0]), 32'h0000_0033);
      chk("seq.count",    32'(o_cnt[0]), 32'((cnt0 + 3) % 256));

      // Random transfers, occasionally with pulses too short to survive every depth
      repeat (40) begin
         if ($urandom_range(0, 7) == 0)
            xfer(8'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(6, 9)));
         else
            xfer(8'($urandom), int'($urandom_range(6, 10)), int'($urandom_range(6, 10)));
      end

      // Reset while the chain is partly filled, enable left asserted through release
      cur_en = !cur_en;
      repeat (3) cycle(cur_en, 8'h77);
      #3;
      RST = 1'b1;
      #1;
      model_clear();
      check_all("async_reset");
      repeat (3) begin
         @(posedge CLK);
         #1;
         check_all("in_reset");
      end
      RST = 1'b0;
      repeat (10) cycle(cur_en, 8'h77);
`ifndef TOGGLE_MODE_EN
      cur_en = 1'b0;
`endif
      repeat (8) cycle(cur_en, 8'($urandom));
      xfer(8'hC3, 7, 8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Absolute time bound so the run always terminates
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected completion before 200000");
      $fatal(1, "timeout");
   end

endmodule
